valid_scheduler: RTL and testbench

//   Sequences test-sample valid pulses for N_CH stimulus channels that share one DUT input port.

---
 rtl/valid_sched_pkg.sv | 14 +
 rtl/valid_chan_timer.sv | 50 +++++
 rtl/valid_scheduler.sv | 135 +++++++++++++
 tb/tb_valid_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/valid_sched_pkg.sv
// Shared types for the valid scheduler: run-state encoding and a channel index type.
package valid_sched_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int N_CH_DEFAULT = 4;
    typedef logic [$clog2(N_CH_DEFAULT)-1:0] ch_idx_t;

    // States in which a new run may be started and periods may be written.
    function automatic logic is_quiet(input state_t s);
        return (s == IDLE) || (s == DONE);
    endfunction

endpackage

// File: rtl/valid_chan_timer.sv
// Per-channel period timer: free-running counter that raises a pending request each
// period, plus a sticky overflow flag for requests lost while one is still pending.
module valid_chan_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             en,
    input  logic             clr,
    input  logic             flush,
    input  logic             grant_ack,
    input  logic [CNT_W-1:0] period,
    output logic             pending,
    output logic             ovf
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic             expire;

    assign expire = run && en && (period != '0) && (cnt == period - ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            pending <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (!run || clr)
                cnt <= '0;
            else if (en && (period != '0))
                cnt <= expire ? '0 : cnt + ONE;

            // A fresh expiry wins over an acknowledge in the same cycle.
            if (clr || flush)
                pending <= 1'b0;
            else if (expire)
                pending <= 1'b1;
            else if (grant_ack)
                pending <= 1'b0;

            if (clr)
                ovf <= 1'b0;
            else if (expire && pending && !grant_ack)
                ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/valid_scheduler.sv
// Shares one valid/ready sample port among N_CH periodic stimulus channels using a
// registered round-robin arbiter, with a start/stop/run-length controlled run FSM.
module valid_scheduler
    import valid_sched_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int CNT_W  = 8,
    parameter  int SAMP_W = 32,
    localparam int CH_W   = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [SAMP_W-1:0] run_len,
    input  logic              start,
    input  logic              stop,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [N_CH-1:0]   ovf,
    output logic [SAMP_W-1:0] samp_cnt
);
    state_t            state, state_nx;
    logic [CNT_W-1:0]  period [N_CH];
    logic [N_CH-1:0]   pending, grant_ack, eff_pend;
    logic [SAMP_W-1:0] run_len_q, cnt_nx;
    logic [CH_W-1:0]   rr_ptr, start_ptr, gnt_ch;
    logic              gnt_vld, issue, transfer, start_fire, flush, hit;

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
        return (int'(c) == N_CH - 1) ? '0 : c + 1'b1;
    endfunction

    function automatic logic [SAMP_W-1:0] sat_inc(input logic [SAMP_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign transfer   = out_valid && out_ready;
    assign start_fire = is_quiet(state) && start;
    assign flush      = (state == DRAIN) && (state_nx == DONE);
    assign cnt_nx     = transfer ? sat_inc(samp_cnt) : samp_cnt;
    assign hit        = (run_len_q != '0) && (cnt_nx >= run_len_q);
    assign busy       = (state == RUN) || (state == DRAIN);
    assign done       = (state == DONE);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        assign grant_ack[i] = transfer && (out_ch == CH_W'(i));
        valid_chan_timer #(.CNT_W(CNT_W)) u_timer (
            .clk       (clk),
            .rst       (rst),
            .run       (state == RUN),
            .en        (en),
            .clr       (start_fire),
            .flush     (flush),
            .grant_ack (grant_ack[i]),
            .period    (period[i]),
            .pending   (pending[i]),
            .ovf       (ovf[i])
        );
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = RUN;
            RUN:        if (stop || hit) state_nx = DRAIN;
            DRAIN:      if (!out_valid || transfer) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    // The channel being accepted this cycle is masked so it cannot be re-issued on
    // a pending bit that is about to clear; the search starts just past it.
    always_comb begin
        eff_pend  = pending;
        start_ptr = rr_ptr;
        if (transfer) begin
            eff_pend[out_ch] = 1'b0;
            start_ptr        = next_ch(out_ch);
        end
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        for (int k = 0; k < N_CH; k++) begin
            int idx;
            idx = (int'(start_ptr) + k) % N_CH;
            if (!gnt_vld && eff_pend[idx]) begin
                gnt_vld = 1'b1;
                gnt_ch  = CH_W'(idx);
            end
        end
        issue = (state == RUN) && (state_nx == RUN) && (!out_valid || transfer) && gnt_vld;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_ch    <= '0;
            rr_ptr    <= '0;
            samp_cnt  <= '0;
            run_len_q <= '0;
            cfg_err   <= 1'b0;
            for (int i = 0; i < N_CH; i++) period[i] <= '0;
        end else begin
            state   <= state_nx;
            cfg_err <= cfg_we && !is_quiet(state);
            if (cfg_we && is_quiet(state) && (int'(cfg_ch) < N_CH))
                period[cfg_ch] <= cfg_period;

            if (start_fire) begin
                samp_cnt  <= '0;
                run_len_q <= run_len;
            end else begin
                samp_cnt <= cnt_nx;
            end

            if (transfer)
                rr_ptr <= start_ptr;

            if (issue) begin
                out_valid <= 1'b1;
                out_ch    <= gnt_ch;
            end else if (transfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_valid_scheduler.sv
// Directed bench for valid_scheduler: a per-cycle vector table plus hand-written
// sequences for period timing, back-pressure/overflow, drain and mid-run reset.
module tb_valid_scheduler;

    logic        clk, rst, en, cfg_we, start, stop, out_ready;
    logic [1:0]  cfg_ch;
    logic [7:0]  cfg_period;
    logic [31:0] run_len;
    logic        out_valid, busy, done, cfg_err;
    logic [1:0]  out_ch;
    logic [3:0]  ovf;
    logic [31:0] samp_cnt;

    int total = 0;
    int bad   = 0;

    valid_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .run_len    (run_len),
        .start      (start),
        .stop       (stop),
        .out_valid  (out_valid),
        .out_ch     (out_ch),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .ovf        (ovf),
        .samp_cnt   (samp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [1:0] ch;
        logic [7:0] per;
        logic       st;
        logic       sp;
        logic       rdy;
        logic       ev;
        logic [1:0] ech;
        logic       ebusy;
        logic       edone;
        logic       eerr;
        int         ecnt;
    } vec_t;

    vec_t tbl [23];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] c, input logic [7:0] p);
        cfg_we = 1'b1; cfg_ch = c; cfg_period = p;
        step();
        cfg_we = 1'b0;
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] ch, input logic [7:0] per,
                                input logic st, input logic sp, input logic ev,
                                input logic [1:0] ech, input logic eb, input logic ed,
                                input logic ee, input int ec);
        vec_t v;
        v.we = we; v.ch = ch; v.per = per; v.st = st; v.sp = sp; v.rdy = 1'b1;
        v.ev = ev; v.ech = ech; v.ebusy = eb; v.edone = ed; v.eerr = ee; v.ecnt = ec;
        return v;
    endfunction

    initial begin
        int c, pulses, first, last;
        bit gap_ok, seen;

        rst = 1'b1; en = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
        run_len = '0; start = 1'b0; stop = 1'b0; out_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_ovf",   {28'd0, ovf}, 32'd0);
        chk("rst_cnt",   samp_cnt, 32'd0);

        // Two channels at period 1: alternating grants, stop, drain, cfg in RUN/DONE.
        //            we  ch per  st sp  ev ech busy done err cnt
        tbl[0]  = mk(1, 0, 1,  0, 0,  0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 1,  0, 0,  0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0,  1, 0,  0, 0, 1, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0,  0, 0,  0, 0, 1, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0,  0, 0,  1, 0, 1, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0,  0, 0,  1, 1, 1, 0, 0, 1);
        tbl[6]  = mk(0, 0, 0,  0, 0,  1, 0, 1, 0, 0, 2);
        tbl[7]  = mk(0, 0, 0,  0, 0,  1, 1, 1, 0, 0, 3);
        tbl[8]  = mk(0, 0, 0,  0, 1,  0, 0, 1, 0, 0, 4);
        tbl[9]  = mk(0, 0, 0,  0, 0,  0, 0, 0, 1, 0, 4);
        tbl[10] = mk(0, 0, 0,  1, 0,  0, 0, 1, 0, 0, 0);
        tbl[11] = mk(1, 0, 9,  0, 0,  0, 0, 1, 0, 1, 0);
        tbl[12] = mk(0, 0, 0,  0, 0,  1, 0, 1, 0, 0, 0);
        tbl[13] = mk(0, 0, 0,  0, 1,  0, 0, 1, 0, 0, 1);
        tbl[14] = mk(0, 0, 0,  0, 0,  0, 0, 0, 1, 0, 1);
        tbl[15] = mk(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 1);
        tbl[16] = mk(1, 1, 0,  0, 0,  0, 0, 0, 1, 0, 1);
        tbl[17] = mk(0, 0, 0,  1, 0,  0, 0, 1, 0, 0, 0);
        tbl[18] = mk(0, 0, 0,  0, 0,  0, 0, 1, 0, 0, 0);
        tbl[19] = mk(0, 0, 0,  0, 0,  0, 0, 1, 0, 0, 0);
        tbl[20] = mk(0, 0, 0,  0, 0,  0, 0, 1, 0, 0, 0);
        tbl[21] = mk(0, 0, 0,  0, 1,  0, 0, 1, 0, 0, 0);
        tbl[22] = mk(0, 0, 0,  0, 0,  0, 0, 0, 1, 0, 0);

        foreach (tbl[i]) begin
            cfg_we = tbl[i].we; cfg_ch = tbl[i].ch; cfg_period = tbl[i].per;
            start = tbl[i].st; stop = tbl[i].sp; out_ready = tbl[i].rdy;
            step();
            chk($sformatf("t%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ev});
            if (tbl[i].ev)
                chk($sformatf("t%0d_ch", i), {30'd0, out_ch}, {30'd0, tbl[i].ech});
            chk($sformatf("t%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].ebusy});
            chk($sformatf("t%0d_done", i), {31'd0, done}, {31'd0, tbl[i].edone});
            chk($sformatf("t%0d_err", i), {31'd0, cfg_err}, {31'd0, tbl[i].eerr});
            chk($sformatf("t%0d_cnt", i), samp_cnt, tbl[i].ecnt);
        end
        cfg_we = 1'b0; start = 1'b0; stop = 1'b0;

        // Single channel, period 5, run length 3: pulses at cycles 6, 11, 16.
        cfg(0, 8'd5);
        run_len = 32'd3; out_ready = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        pulses = 0; first = -1; last = -1; gap_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (out_valid) begin
                pulses++;
                if (first < 0) first = k;
                else if (k - last != 5) gap_ok = 1'b0;
                last = k;
            end
        end
        chk("p5_first", first, 32'd6);
        chk("p5_pulses", pulses, 32'd3);
        chk("p5_gap", {31'd0, gap_ok}, 32'd1);
        chk("p5_cnt", samp_cnt, 32'd3);
        chk("p5_done", {31'd0, done}, 32'd1);
        chk("p5_busy", {31'd0, busy}, 32'd0);
        chk("p5_ovf", {28'd0, ovf}, 32'd0);

        // Back-pressure: ch0 period 2, ready low; sample held, overflow flagged.
        cfg(0, 8'd2);
        run_len = '0; out_ready = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        c = 0;
        while (!out_valid && c < 10) begin step(); c++; end
        chk("bp_latency", c, 32'd3);
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("bp_hold%0d_valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp_hold%0d_ch", k), {30'd0, out_ch}, 32'd0);
            chk($sformatf("bp_hold%0d_cnt", k), samp_cnt, 32'd0);
        end
        chk("bp_ovf", {28'd0, ovf}, 32'd1);
        stop = 1'b1; step(); stop = 1'b0;
        chk("drain_busy", {31'd0, busy}, 32'd1);
        chk("drain_valid", {31'd0, out_valid}, 32'd1);
        chk("drain_done", {31'd0, done}, 32'd0);
        out_ready = 1'b1; step();
        chk("drain_cnt", samp_cnt, 32'd1);
        chk("drain_to_done", {31'd0, done}, 32'd1);
        chk("drain_valid_low", {31'd0, out_valid}, 32'd0);

        // Reset while a sample is outstanding, then a run with every period at 0.
        cfg(0, 8'd1);
        out_ready = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 6; k++) step();
        out_ready = 1'b0;
        c = 0;
        while (!out_valid && c < 5) begin step(); c++; end
        chk("mr_valid_before", {31'd0, out_valid}, 32'd1);
        chk("mr_cnt_nonzero", {31'd0, samp_cnt != 0}, 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mr_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_ch", {30'd0, out_ch}, 32'd0);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_done", {31'd0, done}, 32'd0);
        chk("mr_err", {31'd0, cfg_err}, 32'd0);
        chk("mr_ovf", {28'd0, ovf}, 32'd0);
        chk("mr_cnt", samp_cnt, 32'd0);
        out_ready = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("p0_no_valid", {31'd0, seen}, 32'd0);
        chk("p0_busy", {31'd0, busy}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
